piso_tx_scheduler: RTL

Round-robin scheduler that shares one parallel-in/serial-out shifter between NREQ requesters. It arbitrates among pending parallel words, loads the winner into an internal shift register and serialises it with per-frame bit order. It emits framed serial output (valid/first/last), supports an inter-frame gap and a stall input. It sits between parallel producers and a single serial link.

---
 rtl/piso_tx_scheduler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/piso_tx_scheduler.sv
// Round-robin scheduler sharing one parallel-in/serial-out shifter among NREQ
// requesters. Emits framed serial data (valid/first/last) with a per-frame bit
// order, an optional inter-frame gap and a stall input that pauses shifting.
module piso_tx_scheduler #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned GAP   = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NREQ-1:0]          i_req,
    input  logic [NREQ*WIDTH-1:0]    i_req_data,
    input  logic                     i_msb_first,
    input  logic                     i_stall,
    output logic [NREQ-1:0]          o_grant,
    output logic [$clog2(NREQ)-1:0]  o_owner,
    output logic                     o_busy,
    output logic                     o_sdata,
    output logic                     o_svalid,
    output logic                     o_sfirst,
    output logic                     o_slast
);

    localparam int unsigned OW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GapLast = GW'(GAP - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } state_t;

    state_t             r_state;
    logic [OW-1:0]      r_ptr;
    logic [OW-1:0]      r_owner;
    logic [NREQ-1:0]    r_grant;
    logic [WIDTH-1:0]   r_shreg;
    logic               r_order;
    logic [CW-1:0]      r_cnt;
    logic [GW-1:0]      r_gcnt;
    logic               r_sdata;
    logic               r_svalid;
    logic               r_sfirst;
    logic               r_slast;

    logic [OW-1:0]      w_cand;
    logic [OW-1:0]      w_win;
    logic               w_win_vld;
    logic [WIDTH-1:0]   w_word;

    // Round-robin pick: first requester set after the last winner, wrapping.
    always_comb begin
        w_cand    = '0;
        w_win     = '0;
        w_win_vld = 1'b0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            w_cand = OW'((int'(r_ptr) + k) % int'(NREQ));
            if (!w_win_vld && i_req[w_cand]) begin
                w_win_vld = 1'b1;
                w_win     = w_cand;
            end
        end
    end

    assign w_word = i_req_data[int'(w_win)*WIDTH +: WIDTH];

    // Single FSM: arbitration, load, serialisation, gap and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_ptr    <= OW'(NREQ - 1);
            r_owner  <= '0;
            r_grant  <= '0;
            r_shreg  <= '0;
            r_order  <= 1'b0;
            r_cnt    <= '0;
            r_gcnt   <= '0;
            r_sdata  <= 1'b0;
            r_svalid <= 1'b0;
            r_sfirst <= 1'b0;
            r_slast  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_grant  <= '0;
                    r_sdata  <= 1'b0;
                    r_svalid <= 1'b0;
                    r_sfirst <= 1'b0;
                    r_slast  <= 1'b0;
                    if (w_win_vld) begin
                        r_shreg <= w_word;
                        r_order <= i_msb_first;
                        r_grant <= NREQ'(1) << w_win;
                        r_owner <= w_win;
                        r_ptr   <= w_win;
                        r_cnt   <= '0;
                        r_state <= StShift;
                    end
                end
                StShift: begin
                    r_grant <= '0;
                    if (i_stall) begin
                        // Hold shreg, cnt and sdata so no bit is lost or repeated.
                        r_svalid <= 1'b0;
                        r_sfirst <= 1'b0;
                        r_slast  <= 1'b0;
                    end else begin
                        r_sdata  <= r_order ? r_shreg[WIDTH-1] : r_shreg[0];
                        r_shreg  <= r_order ? {r_shreg[WIDTH-2:0], 1'b0}
                                            : {1'b0, r_shreg[WIDTH-1:1]};
                        r_svalid <= 1'b1;
                        r_sfirst <= (r_cnt == '0);
                        r_slast  <= (r_cnt == CntLast);
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == CntLast) begin
                            r_gcnt  <= '0;
                            r_state <= (GAP > 0) ? StGap : StIdle;
                        end
                    end
                end
                StGap: begin
                    r_sdata  <= 1'b0;
                    r_svalid <= 1'b0;
                    r_sfirst <= 1'b0;
                    r_slast  <= 1'b0;
                    if (r_gcnt == GapLast) begin
                        r_state <= StIdle;
                    end else begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_grant  = r_grant;
    assign o_owner  = r_owner;
    assign o_busy   = (r_state != StIdle);
    assign o_sdata  = r_sdata;
    assign o_svalid = r_svalid;
    assign o_sfirst = r_sfirst;
    assign o_slast  = r_slast;

endmodule
